// File: rtl/pcileech_heci_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pcileech_heci_pkg
// Description : Shared types and constants for the HECI (MEI) controller.
// Revision    : 1.0
// ============================================================================
package pcileech_heci_pkg;

  typedef enum logic [3:0] {
    ME_RESET  = 4'h0,
    ME_INIT   = 4'h1,
    ME_READY  = 4'h4,
    ME_NORMAL = 4'h5
  } me_state_e;

  localparam int H_IE_BIT       = 0;
  localparam int H_IS_BIT       = 1;
  localparam int H_IG_BIT       = 2;
  localparam int H_RDY_BIT      = 3;
  localparam int H_RST_BIT      = 4;

  // Dword indices (byte offset >> 2)
  localparam logic [5:0] REG_H_CSR      = 6'h00;
  localparam logic [5:0] REG_ME_CB_RW   = 6'h01;
  localparam logic [5:0] REG_RSV_08     = 6'h02;
  localparam logic [5:0] REG_ME_CSR_HA  = 6'h03;
  localparam logic [5:0] REG_RSV_10     = 6'h04;
  localparam logic [5:0] REG_D0I3C      = 6'h05;
  localparam logic [5:0] REG_FWSTS_LO   = 6'h10;
  localparam logic [5:0] REG_FWSTS_HI   = 6'h14;
  localparam logic [5:0] REG_CB_WR_BASE = 6'h20;

  localparam logic [31:0] RSV_VALUE     = 32'h0000_0080;
  localparam int          CB_DEPTH      = 32;
  localparam logic [7:0]  CB_DEPTH_BYTE = 8'h20;

  function automatic logic [31:0] fwsts_value(input logic [2:0] idx);
    case (idx)
      3'd0:    return 32'h9000_0255;
      3'd1:    return 32'h8910_0116;
      3'd2:    return 32'h0000_0020;
      3'd3:    return 32'h0000_4000;
      3'd4:    return 32'h0010_0000;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/pcileech_heci_cb.sv
`default_nettype none
// ============================================================================
// Module      : pcileech_heci_cb
// Description : 32 x 32-bit circular buffer with free-running 8-bit pointers.
// Revision    : 1.0
// ============================================================================
module pcileech_heci_cb
  import pcileech_heci_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        push,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic [31:0] head,
  output logic        full,
  output logic        empty,
  output logic [7:0]  wp,
  output logic [7:0]  rp
);

  logic [31:0] r_mem [CB_DEPTH];
  logic [7:0]  r_wp;
  logic [7:0]  r_rp;
  logic [7:0]  w_count;
  logic        w_push;
  logic        w_pop;

  assign w_count = r_wp - r_rp;
  assign full    = (w_count == CB_DEPTH_BYTE);
  assign empty   = (w_count == 8'd0);
  assign w_push  = push & ~full;
  assign w_pop   = pop & ~empty;
  assign head    = r_mem[r_rp[4:0]];
  assign wp      = r_wp;
  assign rp      = r_rp;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 8'd1;
      if (w_pop)  r_rp <= r_rp + 8'd1;
    end
  end

  // Storage carries no reset; only entries between rp and wp are ever observed.
  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wp[4:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/pcileech_heci_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pcileech_heci_ctrl
// Description : HECI register block, emulated ME state machine and CB glue.
// Revision    : 1.0
// ============================================================================
module pcileech_heci_ctrl
  import pcileech_heci_pkg::*;
#(
  parameter int RESET_CYCLES = 64,
  parameter int INIT_CYCLES  = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bar_wr_valid,
  input  logic [7:0]  bar_wr_addr,
  input  logic [3:0]  bar_wr_be,
  input  logic [31:0] bar_wr_data,
  input  logic        bar_rd_valid,
  input  logic [7:0]  bar_rd_addr,
  output logic [31:0] bar_rd_data,
  output logic        bar_rd_rsp_valid,
  output logic [31:0] msg_out_data,
  output logic        msg_out_valid,
  input  logic        msg_out_ready,
  input  logic [31:0] msg_in_data,
  input  logic        msg_in_last,
  input  logic        msg_in_valid,
  output logic        msg_in_ready,
  output logic        me_doorbell,
  output logic [3:0]  me_state,
  output logic        irq
);

  localparam logic [15:0] RST_LAST  = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] INIT_LAST = 16'(INIT_CYCLES - 1);

  me_state_e   r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic        r_h_ie, r_h_is, r_h_rdy, r_h_rst, r_doorbell, r_rd_rsp_valid;
  logic [31:0] r_d0i3c, r_rd_data, w_rd_value;
  logic [5:0]  w_wr_idx, w_rd_idx;
  logic        w_hcsr_wr, w_rst_req, w_flush, w_normal, w_is_set, w_me_rdy;
  logic        w_h_full, w_h_empty, w_m_full, w_m_empty, w_m_push;
  logic [31:0] w_h_head, w_m_head;
  logic [7:0]  w_h_wp, w_h_rp, w_m_wp, w_m_rp;
  logic        w_unused_addr_lsbs;

  assign w_unused_addr_lsbs = ^{bar_wr_addr[1:0], bar_rd_addr[1:0]};
  assign w_wr_idx  = bar_wr_addr[7:2];
  assign w_rd_idx  = bar_rd_addr[7:2];
  assign w_hcsr_wr = bar_wr_valid & (w_wr_idx == REG_H_CSR) & bar_wr_be[0];
  assign w_rst_req = w_hcsr_wr & bar_wr_data[H_RST_BIT];
  assign w_flush   = (r_state == ME_RESET) | w_rst_req;
  assign w_normal  = (r_state == ME_NORMAL);
  assign w_me_rdy  = (r_state == ME_READY) | w_normal;

  assign msg_out_valid = ~w_h_empty & w_normal;
  assign msg_out_data  = msg_out_valid ? w_h_head : 32'h0;
  assign msg_in_ready  = ~w_m_full & w_normal;
  assign w_m_push      = msg_in_valid & msg_in_ready;

  pcileech_heci_cb u_host_cb (
    .clk(clk), .rst_n(rst_n), .flush(w_flush),
    .push(bar_wr_valid & (w_wr_idx >= REG_CB_WR_BASE)), .push_data(bar_wr_data),
    .pop(msg_out_valid & msg_out_ready), .head(w_h_head),
    .full(w_h_full), .empty(w_h_empty), .wp(w_h_wp), .rp(w_h_rp)
  );

  pcileech_heci_cb u_me_cb (
    .clk(clk), .rst_n(rst_n), .flush(w_flush),
    .push(w_m_push), .push_data(msg_in_data),
    .pop(bar_rd_valid & (w_rd_idx == REG_ME_CB_RW)), .head(w_m_head),
    .full(w_m_full), .empty(w_m_empty), .wp(w_m_wp), .rp(w_m_rp)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ME_RESET;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A host reset request overrides every state and restarts the dwell counter.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_rst_req) begin
      w_state_nxt = ME_RESET;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ME_RESET: begin
          if (r_cnt >= RST_LAST && !r_h_rst) begin
            w_state_nxt = ME_INIT;
            w_cnt_nxt   = '0;
          end else if (r_cnt < RST_LAST) begin
            w_cnt_nxt = r_cnt + 16'd1;
          end
        end
        ME_INIT: begin
          if (r_cnt >= INIT_LAST) begin
            w_state_nxt = ME_READY;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 16'd1;
          end
        end
        ME_READY: begin
          if (w_hcsr_wr && bar_wr_data[H_RDY_BIT]) w_state_nxt = ME_NORMAL;
        end
        default: ;
      endcase
    end
  end

  assign w_is_set = ((r_state == ME_INIT) && (w_state_nxt == ME_READY)) |
                    (w_m_push & msg_in_last);

  always_comb begin
    w_rd_value = '0;
    case (w_rd_idx)
      REG_H_CSR:     w_rd_value = {CB_DEPTH_BYTE, w_h_wp, w_h_rp, 3'b000,
                                   r_h_rst, r_h_rdy, 1'b0, r_h_is, r_h_ie};
      REG_ME_CB_RW:  w_rd_value = w_m_empty ? 32'h0 : w_m_head;
      REG_RSV_08,
      REG_RSV_10:    w_rd_value = RSV_VALUE;
      REG_ME_CSR_HA: w_rd_value = {CB_DEPTH_BYTE, w_m_wp, w_m_rp, 3'b000,
                                   (r_state == ME_RESET), w_me_rdy, 3'b000};
      REG_D0I3C:     w_rd_value = r_d0i3c;
      default: begin
        if (w_rd_idx >= REG_FWSTS_LO && w_rd_idx <= REG_FWSTS_HI)
          w_rd_value = fwsts_value(w_rd_idx[2:0]);
      end
    endcase
  end

  // H_IS: hardware set takes priority over a same-cycle write-1-to-clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_h_ie         <= 1'b0;
      r_h_is         <= 1'b0;
      r_h_rdy        <= 1'b0;
      r_h_rst        <= 1'b0;
      r_doorbell     <= 1'b0;
      r_d0i3c        <= '0;
      r_rd_rsp_valid <= 1'b0;
      r_rd_data      <= '0;
    end else begin
      r_doorbell <= w_hcsr_wr & bar_wr_data[H_IG_BIT];
      if (w_hcsr_wr) begin
        r_h_ie  <= bar_wr_data[H_IE_BIT];
        r_h_rdy <= bar_wr_data[H_RDY_BIT];
        r_h_rst <= bar_wr_data[H_RST_BIT];
      end
      if (w_is_set)
        r_h_is <= 1'b1;
      else if (w_hcsr_wr && bar_wr_data[H_IS_BIT])
        r_h_is <= 1'b0;
      if (bar_wr_valid && w_wr_idx == REG_D0I3C) begin
        for (int b = 0; b < 4; b++) begin
          if (bar_wr_be[b]) r_d0i3c[8*b +: 8] <= bar_wr_data[8*b +: 8];
        end
      end
      r_rd_rsp_valid <= bar_rd_valid;
      r_rd_data      <= bar_rd_valid ? w_rd_value : 32'h0;
    end
  end

  assign bar_rd_data      = r_rd_data;
  assign bar_rd_rsp_valid = r_rd_rsp_valid;
  assign me_doorbell      = r_doorbell;
  assign me_state         = r_state;
  assign irq              = r_h_is & r_h_ie;

endmodule
`default_nettype wire

// File: tb/tb_pcileech_heci_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcileech_heci_ctrl
// Description : Self-checking bench with queue-based reference model.
// Revision    : 1.0
// ============================================================================
module tb_pcileech_heci_ctrl;

  localparam int RESET_CYCLES = 64;
  localparam int INIT_CYCLES  = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bar_wr_valid = 1'b0;
  logic [7:0]  bar_wr_addr = '0;
  logic [3:0]  bar_wr_be = '0;
  logic [31:0] bar_wr_data = '0;
  logic        bar_rd_valid = 1'b0;
  logic [7:0]  bar_rd_addr = '0;
  logic [31:0] bar_rd_data;
  logic        bar_rd_rsp_valid;
  logic [31:0] msg_out_data;
  logic        msg_out_valid;
  logic        msg_out_ready = 1'b0;
  logic [31:0] msg_in_data = '0;
  logic        msg_in_last = 1'b0;
  logic        msg_in_valid = 1'b0;
  logic        msg_in_ready;
  logic        me_doorbell;
  logic [3:0]  me_state;
  logic        irq;

  always #5 clk = ~clk;

  pcileech_heci_ctrl #(.RESET_CYCLES(RESET_CYCLES), .INIT_CYCLES(INIT_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .bar_wr_valid(bar_wr_valid), .bar_wr_addr(bar_wr_addr), .bar_wr_be(bar_wr_be),
    .bar_wr_data(bar_wr_data), .bar_rd_valid(bar_rd_valid), .bar_rd_addr(bar_rd_addr),
    .bar_rd_data(bar_rd_data), .bar_rd_rsp_valid(bar_rd_rsp_valid),
    .msg_out_data(msg_out_data), .msg_out_valid(msg_out_valid), .msg_out_ready(msg_out_ready),
    .msg_in_data(msg_in_data), .msg_in_last(msg_in_last), .msg_in_valid(msg_in_valid),
    .msg_in_ready(msg_in_ready), .me_doorbell(me_doorbell), .me_state(me_state), .irq(irq)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_state = 0;
  int          m_since = 0;
  bit          m_live = 0, m_ie = 0, m_is = 0, m_rdy = 0, m_rst = 0, m_db = 0, m_rspv = 0;
  logic [31:0] m_d0i3c = '0, m_rdata = '0;
  logic [31:0] m_hq[$];
  logic [31:0] m_mq[$];
  logic [7:0]  m_hwp = '0, m_hrp = '0, m_mwp = '0, m_mrp = '0;

  function automatic logic [31:0] fw(input int i);
    case (i)
      0: return 32'h9000_0255;
      1: return 32'h8910_0116;
      2: return 32'h0000_0020;
      3: return 32'h0000_4000;
      4: return 32'h0010_0000;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a);
    int w = int'(a) / 4;
    if (w == 0) return {8'h20, m_hwp, m_hrp, 3'b000, m_rst, m_rdy, 1'b0, m_is, m_ie};
    if (w == 1) return (m_mq.size() > 0) ? m_mq[0] : 32'h0;
    if (w == 2 || w == 4) return 32'h80;
    if (w == 3) return {8'h20, m_mwp, m_mrp, 3'b000, (m_state == 0), (m_state >= 4), 3'b000};
    if (w == 5) return m_d0i3c;
    if (w >= 16 && w <= 20) return fw(w - 16);
    return 32'h0;
  endfunction

  always @(posedge clk) begin : model
    int wi, ri, nstate, nsince;
    bit hcsr, rstreq, flush, hpop, hpush, mpush, mpop, setis;
    if (!rst_n) begin
      m_live = 1; m_state = 0; m_since = 0;
      m_ie = 0; m_is = 0; m_rdy = 0; m_rst = 0; m_db = 0; m_rspv = 0;
      m_d0i3c = '0; m_rdata = '0;
      m_hq.delete(); m_mq.delete();
      m_hwp = 0; m_hrp = 0; m_mwp = 0; m_mrp = 0;
    end else begin
      wi     = int'(bar_wr_addr) / 4;
      ri     = int'(bar_rd_addr) / 4;
      hcsr   = bar_wr_valid && wi == 0 && bar_wr_be[0];
      rstreq = hcsr && bar_wr_data[4];
      flush  = (m_state == 0) || rstreq;
      hpop   = m_hq.size() > 0 && m_state == 5 && msg_out_ready;
      hpush  = bar_wr_valid && wi >= 32 && m_hq.size() < 32;
      mpush  = msg_in_valid && m_mq.size() < 32 && m_state == 5;
      mpop   = bar_rd_valid && ri == 1 && m_mq.size() > 0;
      m_rspv  = bar_rd_valid;
      m_rdata = bar_rd_valid ? model_read(bar_rd_addr) : 32'h0;

      nstate = m_state;
      if (rstreq) nstate = 0;
      else if (m_state == 0 && m_since + 1 >= RESET_CYCLES && !m_rst) nstate = 1;
      else if (m_state == 1 && m_since + 1 >= INIT_CYCLES) nstate = 4;
      else if (m_state == 4 && hcsr && bar_wr_data[3]) nstate = 5;
      nsince = (rstreq || nstate != m_state) ? 0 : m_since + 1;

      setis = (m_state == 1 && nstate == 4) || (mpush && msg_in_last);
      if (setis) m_is = 1;
      else if (hcsr && bar_wr_data[1]) m_is = 0;
      if (hcsr) begin
        m_ie = bar_wr_data[0]; m_rdy = bar_wr_data[3]; m_rst = bar_wr_data[4];
      end
      m_db = hcsr && bar_wr_data[2];
      if (bar_wr_valid && wi == 5)
        for (int b = 0; b < 4; b++)
          if (bar_wr_be[b]) m_d0i3c[8*b +: 8] = bar_wr_data[8*b +: 8];

      if (flush) begin
        m_hq.delete(); m_mq.delete();
        m_hwp = 0; m_hrp = 0; m_mwp = 0; m_mrp = 0;
      end else begin
        if (hpop)  begin void'(m_hq.pop_front()); m_hrp++; end
        if (hpush) begin m_hq.push_back(bar_wr_data); m_hwp++; end
        if (mpop)  begin void'(m_mq.pop_front()); m_mrp++; end
        if (mpush) begin m_mq.push_back(msg_in_data); m_mwp++; end
      end
      m_state = nstate;
      m_since = nsince;
    end
  end

  always @(negedge clk) begin : compare
    bit ov;
    if (m_live) begin
      ov = m_hq.size() > 0 && m_state == 5;
      check("me_state", 32'(me_state), 32'(m_state));
      check("irq", 32'(irq), 32'(m_is & m_ie));
      check("msg_out_valid", 32'(msg_out_valid), 32'(ov));
      check("msg_in_ready", 32'(msg_in_ready), 32'(m_mq.size() < 32 && m_state == 5));
      check("me_doorbell", 32'(me_doorbell), 32'(m_db));
      check("rd_rsp_valid", 32'(bar_rd_rsp_valid), 32'(m_rspv));
      if (ov)     check("msg_out_data", msg_out_data, m_hq[0]);
      if (m_rspv) check("rd_data", bar_rd_data, m_rdata);
    end
  end

  // ---------------- stimulus ----------------
  task automatic mmio_wr(input logic [7:0] a, input logic [31:0] d);
    bar_wr_valid = 1'b1; bar_wr_addr = a; bar_wr_data = d; bar_wr_be = 4'hF;
    @(negedge clk);
    bar_wr_valid = 1'b0;
  endtask

  task automatic mmio_rd(input logic [7:0] a, output logic [31:0] d);
    bar_rd_valid = 1'b1; bar_rd_addr = a;
    @(negedge clk);
    bar_rd_valid = 1'b0;
    d = bar_rd_data;
  endtask

  initial begin : stim
    logic [31:0] rd;
    logic [31:0] vals [33];
    int cyc, n, sel;

    repeat (3) @(negedge clk);
    check("rst_state", 32'(me_state), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_out_valid", 32'(msg_out_valid), 32'h0);
    check("rst_in_ready", 32'(msg_in_ready), 32'h0);
    rst_n = 1'b1;

    cyc = 0;
    while (cyc < 1000 && me_state != 4'h4) begin
      @(negedge clk);
      cyc++;
    end
    check("ready_latency", 32'(cyc), 32'(RESET_CYCLES + INIT_CYCLES));

    mmio_rd(8'h0C, rd); check("me_csr_ha_ready", rd, 32'h2000_0008);
    mmio_rd(8'h00, rd); check("h_csr_ready", rd, 32'h2000_0002);
    mmio_wr(8'h00, 32'h1); check("irq_enabled", 32'(irq), 32'h1);
    mmio_wr(8'h00, 32'h9); check("state_normal", 32'(me_state), 32'h5);
    mmio_wr(8'h00, 32'hB); check("irq_cleared", 32'(irq), 32'h0);
    mmio_rd(8'h44, rd); check("fwsts2", rd, 32'h8910_0116);

    msg_out_ready = 1'b0;
    for (int i = 0; i < 33; i++) begin
      vals[i] = $urandom;
      mmio_wr(8'(8'h80 + 4 * (i % 32)), vals[i]);
    end
    mmio_rd(8'h00, rd); check("h_cbwp_full", 32'(rd[23:8]), 32'h2000);
    msg_out_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (msg_out_valid) begin
        if (n < 32) check("drain_order", msg_out_data, vals[n]);
        n++;
      end
      @(negedge clk);
    end
    msg_out_ready = 1'b0;
    check("drain_count", 32'(n), 32'd32);
    mmio_rd(8'h00, rd); check("h_ptrs_drained", 32'(rd[23:8]), 32'h2020);

    msg_in_valid = 1'b1; msg_in_data = 32'hA; msg_in_last = 1'b0;
    @(negedge clk); msg_in_data = 32'hB;
    @(negedge clk); msg_in_data = 32'hC; msg_in_last = 1'b1;
    @(negedge clk); msg_in_valid = 1'b0; msg_in_last = 1'b0;
    mmio_rd(8'h00, rd); check("h_is_on_last", 32'(rd[1]), 32'h1);
    mmio_rd(8'h04, rd); check("me_cb_0", rd, 32'hA);
    mmio_rd(8'h04, rd); check("me_cb_1", rd, 32'hB);
    mmio_rd(8'h04, rd); check("me_cb_2", rd, 32'hC);
    mmio_rd(8'h04, rd); check("me_cb_empty", rd, 32'h0);

    for (int i = 0; i < 5; i++) mmio_wr(8'h80, 32'h100 + 32'(i));
    msg_in_valid = 1'b1; msg_in_data = 32'h55;
    @(negedge clk);
    mmio_wr(8'h00, 32'h19);
    msg_in_valid = 1'b0;
    check("hrst_state", 32'(me_state), 32'h0);
    check("hrst_out_valid", 32'(msg_out_valid), 32'h0);
    check("hrst_in_ready", 32'(msg_in_ready), 32'h0);
    mmio_rd(8'h00, rd); check("hrst_h_ptrs", 32'(rd[23:8]), 32'h0);
    mmio_rd(8'h0C, rd); check("hrst_me_csr", rd, 32'h2000_0010);

    mmio_wr(8'h00, 32'h4);
    check("doorbell_pulse", 32'(me_doorbell), 32'h1);
    @(negedge clk);
    check("doorbell_end", 32'(me_doorbell), 32'h0);
    mmio_rd(8'h00, rd); check("h_ig_reads_0", 32'(rd[2]), 32'h0);

    for (int c = 0; c < 8000; c++) begin
      bar_wr_valid = ($urandom_range(0, 3) == 0);
      bar_wr_be    = 4'($urandom);
      bar_wr_data  = $urandom;
      sel          = $urandom_range(0, 15);
      if (sel < 6) bar_wr_addr = 8'h80 | 8'($urandom);
      else if (sel < 8) begin
        bar_wr_addr    = 8'($urandom_range(0, 3));
        bar_wr_data[4] = ($urandom_range(0, 31) == 0);
        bar_wr_data[3] = ($urandom_range(0, 3) != 0);
      end
      else if (sel < 10) bar_wr_addr = 8'h14;
      else bar_wr_addr = 8'($urandom);
      bar_rd_valid  = ($urandom_range(0, 2) == 0);
      bar_rd_addr   = ($urandom_range(0, 1) == 0) ? 8'h04 : 8'($urandom);
      msg_in_valid  = 1'($urandom_range(0, 1));
      msg_in_data   = $urandom;
      msg_in_last   = ($urandom_range(0, 3) == 0);
      msg_out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bar_wr_valid = 1'b0; bar_rd_valid = 1'b0; msg_in_valid = 1'b0; msg_out_ready = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pcileech_heci_ctrl.md
# pcileech_heci_ctrl

HECI (Intel MEI) register and circular-buffer controller for the MEI-emulation personality. Sits behind the BAR0 TLP handler: serves host MMIO reads/writes of the HECI register block, sequences the emulated ME state machine, and moves message dwords between two 32-dword circular buffers and the FIFO-side message streams.

## Interface
- RESET_CYCLES, 64: cycles held in ME_RESET before INIT may start.
- INIT_CYCLES, 256: cycles in ME_INIT before READY.
- clk  in  1  core clock.
- rst_n  in  1  synchronous reset, active low.
- bar_wr_valid  in  1  host MMIO write strobe.
- bar_wr_addr  in  8  byte offset (bits [1:0] ignored).
- bar_wr_be  in  4  byte enables.
- bar_wr_data  in  32  write data.
- bar_rd_valid  in  1  host MMIO read strobe.
- bar_rd_addr  in  8  byte offset.
- bar_rd_data  out  32  read data.
- bar_rd_rsp_valid  out  1  read-response strobe.
- msg_out_data / msg_out_valid / msg_out_ready  out/out/in  32/1/1  host→ME dwords to FIFO.
- msg_in_data / msg_in_last / msg_in_valid / msg_in_ready  in/in/in/out  32/1/1/1  ME→host dwords from FIFO.
- me_doorbell  out  1  one-cycle pulse on host H_IG write.
- me_state  out  4  current ME state encoding.
- irq  out  1  level interrupt request to MSI logic.

## Operation
- States: ME_RESET(0x0) → ME_INIT(0x1) → ME_READY(0x4) → ME_NORMAL(0x5).
- ME_RESET: pointers cleared, ME_RDY=0, ME_RST_HRA=1; leave to INIT after RESET_CYCLES and H_RST==0.
- ME_INIT: after INIT_CYCLES → READY, set ME_RDY=1, ME_RST_HRA=0, set H_IS.
- ME_READY → ME_NORMAL on host write H_CSR with H_RDY=1, H_RST=0.
- Host write H_CSR with H_RST=1 (any state) → ME_RESET next cycle, counter restarts.
- H_CSR (0x00): [0] H_IE RW, [1] H_IS RW1C, [2] H_IG write-1 pulse (reads 0), [3] H_RDY RW, [4] H_RST RW, [15:8] H_CBRP, [23:16] H_CBWP, [31:24] H_CBD=0x20. Pointer/depth fields read-only.
- ME_CB_RW (0x04) read: pop one dword from ME buffer; empty → return 0, no pop. Writes ignored.
- ME_CSR_HA (0x0C): [3] ME_RDY, [4] ME_RST_HRA, [15:8] ME_CBRP, [23:16] ME_CBWP, [31:24] 0x20. Read-only.
- 0x08, 0x10 read 0x00000080. 0x14 D0I3C RW, byte-enabled, reset 0. 0x40–0x50 read package FWSTS constants. 0x80–0xFC write: push to host buffer (byte enables ignored); full → drop. Unmapped: read 0, write ignored.
- Pointers 8-bit free-running; index = ptr[4:0]; count = wp−rp mod 256; full at 32.
- msg_out_valid = host buffer non-empty and state NORMAL. msg_in_ready = ME buffer not full and state NORMAL.
- Accepted msg_in beat with msg_in_last=1 sets H_IS. irq = H_IS & H_IE.

## Timing
- Reset values: bar_rd_data=0, bar_rd_rsp_valid=0, msg_out_valid=0, msg_in_ready=0, me_doorbell=0, me_state=0x0, irq=0; all registers 0.
- Read latency: bar_rd_rsp_valid exactly 1 cycle after bar_rd_valid; data registered.
- Same-cycle read and write: write applies; read returns pre-write value.
- Same-cycle pop (ME_CB_RW read) and msg_in push: both occur, count unchanged.
- Same-cycle H_IS RW1C and hardware set: set wins.
- msg_out_data/valid held until ready; pop on valid&ready.
- H_RST mid-transfer: buffers flushed, valid/ready deassert next cycle; partial messages discarded.

## Structure
- Package pcileech_heci_pkg: ME state enum (header values), H_CSR/ME_CSR_HA bit positions, register offsets, FWSTS constants, CB depth 32.
- Sub-module pcileech_heci_cb: 32×32 circular buffer with 8-bit rd/wr pointers, push/pop/full/empty/count; instantiated twice.

## Test plan
- Reset release, H_RST=0 → ME_READY after RESET_CYCLES+INIT_CYCLES; ME_CSR_HA reads 0x20000008; H_IS=1; with H_IE=1 irq=1.
- Write H_CSR 0x00000009 in READY → me_state=0x5; write 0x2 clears H_IS, irq=0.
- Push 33 dwords to 0x80 with msg_out_ready=0 → H_CBWP=0x20, 33rd dropped; ready=1 → 32 dwords out in order.
- msg_in 3 beats (0xA,0xB,0xC, last on 0xC) → H_IS set; three ME_CB_RW reads return 0xA,0xB,0xC; fourth returns 0.
- Write H_CSR H_RST=1 mid-stream → me_state=0x0 next cycle, pointers 0, msg_out_valid=0.
- Write H_CSR with bit2 set → me_doorbell high exactly one cycle; H_CSR reads bit2=0.
